display_scan_ctrl: RTL

Time-multiplexed scan controller for the 8-digit seven-segment display on the reseller front panel (price, credit, change readout).
- Sequences a 3-bit digit index through fixed-length slots, each with a blanking dead-time to prevent ghosting.
- Holds a 32-bit shadow frame, accepted from the upstream logic only at frame boundaries through a valid/ready handshake.
- Drives active-low anodes and cathodes straight to the board pins.

---
 rtl/display_scan_ctrl_pkg.sv | 37 +++
 rtl/display_scan_ctrl_hex7seg.sv | 11 +
 rtl/display_scan_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants, FSM state encoding and hex-to-segment table for the
// front-panel seven-segment scan controller.
package display_scan_ctrl_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [7:0] AN_OFF    = 8'hFF;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } scan_state_e;

   // Active-low segments, bit order g..a (bit 0 = a).
   function automatic logic [6:0] hex_to_seg(input logic [3:0] i_nib);
      logic [6:0] w_seg;
      case (i_nib)
         4'h0:    w_seg = 7'b1000000;
         4'h1:    w_seg = 7'b1111001;
         4'h2:    w_seg = 7'b0100100;
         4'h3:    w_seg = 7'b0110000;
         4'h4:    w_seg = 7'b0011001;
         4'h5:    w_seg = 7'b0010010;
         4'h6:    w_seg = 7'b0000010;
         4'h7:    w_seg = 7'b1111000;
         4'h8:    w_seg = 7'b0000000;
         4'h9:    w_seg = 7'b0010000;
         4'hA:    w_seg = 7'b0001000;
         4'hB:    w_seg = 7'b0000011;
         4'hC:    w_seg = 7'b1000110;
         4'hD:    w_seg = 7'b0100001;
         4'hE:    w_seg = 7'b0000110;
         default: w_seg = 7'b0001110;
      endcase
      return w_seg;
   endfunction

endpackage

// File: rtl/display_scan_ctrl_hex7seg.sv
// Combinational 4-bit hex to active-low seven-segment decoder.
module hex7seg
   import display_scan_ctrl_pkg::*;
(
   input  logic [3:0] i_nib,
   output logic [6:0] o_seg
);

   assign o_seg = hex_to_seg(i_nib);

endmodule

// File: rtl/display_scan_ctrl.sv
// 8-digit time-multiplexed seven-segment scanner with blanking dead-time and a
// frame-boundary valid/ready load of the 32-bit shadow frame.
module display_scan_ctrl
   import display_scan_ctrl_pkg::*;
#(
   parameter int DIV       = 50000,
   parameter int BLANK_CYC = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] frame_data,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic [7:0]  digit_en_mask,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        frame_done
);

   localparam int              CW     = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0]   C_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0]   C_BLK  = CW'(BLANK_CYC - 1);

   logic [CW-1:0] r_cnt;
   logic [2:0]    r_idx;
   scan_state_e   r_state;
   logic [31:0]   r_shadow;
   logic [7:0]    r_an;
   logic [6:0]    r_seg;
   logic          r_ready;

   logic          w_slot_end;
   logic [CW-1:0] w_cnt_nxt;
   logic [2:0]    w_idx_nxt;
   scan_state_e   w_state_nxt;
   logic [31:0]   w_shadow_nxt;
   logic [3:0]    w_nib;
   logic [6:0]    w_seg;

   assign w_slot_end = (r_cnt == C_LAST);
   assign w_cnt_nxt  = w_slot_end ? '0 : r_cnt + 1'b1;

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      case (r_state)
         ST_BLANK: if (r_cnt == C_BLK) w_state_nxt = ST_DRIVE;
         ST_DRIVE: if (w_slot_end) begin
            w_state_nxt = ST_BLANK;
            w_idx_nxt   = r_idx + 3'd1;
         end
         default:  w_state_nxt = ST_BLANK;
      endcase
   end

   // r_ready marks the current cycle as the frame boundary, so it doubles as
   // the acceptance qualifier for the handshake.
   assign w_shadow_nxt = (r_ready && load_valid) ? frame_data : r_shadow;
   assign w_nib        = w_shadow_nxt[{w_idx_nxt, 2'b00} +: 4];

   hex7seg u_dec (
      .i_nib (w_nib),
      .o_seg (w_seg)
   );

   // Outputs are computed from next-state values so the registered pins line
   // up with the state they describe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_idx    <= 3'd0;
         r_state  <= ST_BLANK;
         r_shadow <= 32'h0;
         r_an     <= AN_OFF;
         r_seg    <= SEG_BLANK;
         r_ready  <= 1'b0;
      end else begin
         r_cnt    <= w_cnt_nxt;
         r_idx    <= w_idx_nxt;
         r_state  <= w_state_nxt;
         r_shadow <= w_shadow_nxt;
         r_ready  <= (w_cnt_nxt == C_LAST) && (w_idx_nxt == 3'd7);
         if (w_state_nxt == ST_DRIVE) begin
            r_an  <= digit_en_mask[w_idx_nxt] ? ~(8'h01 << w_idx_nxt) : AN_OFF;
            r_seg <= w_seg;
         end else begin
            r_an  <= AN_OFF;
            r_seg <= SEG_BLANK;
         end
      end
   end

   assign an         = r_an;
   assign seg        = r_seg;
   assign load_ready = r_ready;
   assign frame_done = r_ready;

endmodule
